// File: rtl/shift_reg_bank.sv
// WIDTH-bit storage/shift register with complementary outputs, mode-selected datapath
// and a built-in parallel-to-serial engine (start -> WIDTH enabled bit times -> done).
module shift_reg_bank #(
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = '0,
  parameter bit               MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] d,
  input  logic             sin,
  input  logic             start,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qn,
  output logic             sout,
  output logic             busy,
  output logic             done
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  localparam logic [2:0] MODE_HOLD = 3'b000;
  localparam logic [2:0] MODE_LOAD = 3'b001;
  localparam logic [2:0] MODE_SHL  = 3'b010;
  localparam logic [2:0] MODE_SHR  = 3'b011;
  localparam logic [2:0] MODE_ROL  = 3'b100;
  localparam logic [2:0] MODE_ROR  = 3'b101;
  localparam logic [2:0] MODE_CLR  = 3'b110;
  localparam logic [2:0] MODE_INV  = 3'b111;

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] q_reg, q_next;
  logic [CW-1:0]    cnt_reg, cnt_next;
  logic             done_reg, done_next;

  logic [WIDTH-1:0] shl_val, shr_val, rol_val, ror_val, ser_val;

  assign shl_val = {q_reg[WIDTH-2:0], sin};
  assign shr_val = {sin, q_reg[WIDTH-1:1]};
  assign rol_val = {q_reg[WIDTH-2:0], q_reg[WIDTH-1]};
  assign ror_val = {q_reg[0], q_reg[WIDTH-1:1]};

  // The serializer always shifts toward the bit that drives sout.
  generate
    if (MSB_FIRST) begin : g_msb
      assign ser_val = shl_val;
      assign sout    = q_reg[WIDTH-1];
    end else begin : g_lsb
      assign ser_val = shr_val;
      assign sout    = q_reg[0];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      q_reg     <= RESET_VAL;
      cnt_reg   <= '0;
      done_reg  <= 1'b0;
    end else if (en) begin
      state_reg <= state_next;
      q_reg     <= q_next;
      cnt_reg   <= cnt_next;
      done_reg  <= done_next;
    end else begin
      // done is a strict one-cycle pulse, even across a stall.
      done_reg  <= 1'b0;
    end
  end

  always_comb begin
    state_next = state_reg;
    q_next     = q_reg;
    cnt_next   = cnt_reg;
    done_next  = 1'b0;
    case (state_reg)
      IDLE: begin
        if (start) begin
          q_next     = d;
          cnt_next   = CNT_LAST;
          state_next = SHIFT;
        end else begin
          case (mode)
            MODE_HOLD: q_next = q_reg;
            MODE_LOAD: q_next = d;
            MODE_SHL:  q_next = shl_val;
            MODE_SHR:  q_next = shr_val;
            MODE_ROL:  q_next = rol_val;
            MODE_ROR:  q_next = ror_val;
            MODE_CLR:  q_next = RESET_VAL;
            MODE_INV:  q_next = ~q_reg;
          endcase
        end
      end
      SHIFT: begin
        q_next = ser_val;
        if (cnt_reg == '0) begin
          state_next = IDLE;
          done_next  = 1'b1;
        end else begin
          cnt_next = cnt_reg - CW'(1);
        end
      end
      default: state_next = IDLE;
    endcase
  end

  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_qn
      assign qn[gi] = ~q_reg[gi];
    end
  endgenerate

  assign q    = q_reg;
  assign busy = (state_reg == SHIFT);
  assign done = done_reg;

endmodule

// File: tb/tb_shift_reg_bank.sv
// Self-checking bench for shift_reg_bank: one MSB-first and one LSB-first instance share stimulus;
// expected q values and serial bits are queued when driven and popped when the DUT produces them.
module tb_shift_reg_bank;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         en = 1'b0;
  logic [2:0]   mode = 3'b000;
  logic [W-1:0] d = '0;
  logic         sin = 1'b0;
  logic         start = 1'b0;

  logic [W-1:0] q_m, qn_m, q_l, qn_l;
  logic         sout_m, busy_m, done_m, sout_l, busy_l, done_l;

  int tests_run = 0;
  int failures  = 0;

  bit           exp_m[$];
  bit           exp_l[$];
  logic [W-1:0] exp_q[$];

  shift_reg_bank #(.WIDTH(W), .RESET_VAL(8'h00), .MSB_FIRST(1'b1)) dut_msb (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .d(d), .sin(sin), .start(start),
    .q(q_m), .qn(qn_m), .sout(sout_m), .busy(busy_m), .done(done_m)
  );

  shift_reg_bank #(.WIDTH(W), .RESET_VAL(8'h00), .MSB_FIRST(1'b0)) dut_lsb (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .d(d), .sin(sin), .start(start),
    .q(q_l), .qn(qn_l), .sout(sout_l), .busy(busy_l), .done(done_l)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; en = 1'b1; mode = 3'b001; d = 8'hFF; start = 1'b0; sin = 1'b0;
    tick();
    tests_run++;
    if (q_m !== 8'h00 || qn_m !== 8'hFF || busy_m !== 1'b0 || done_m !== 1'b0 ||
        q_l !== 8'h00 || qn_l !== 8'hFF || busy_l !== 1'b0 || done_l !== 1'b0) begin
      failures++;
      $display("FAIL reset: q=%h/%h qn=%h/%h busy=%b/%b done=%b/%b, expected q=00 qn=FF busy=0 done=0",
               q_m, q_l, qn_m, qn_l, busy_m, busy_l, done_m, done_l);
    end
    rst_n = 1'b1; mode = 3'b000; d = '0;
  endtask

  task automatic test_modes();
    logic [2:0]   m_tab[7] = '{3'b010, 3'b011, 3'b100, 3'b101, 3'b111, 3'b110, 3'b000};
    bit           s_tab[7] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    logic [W-1:0] e_tab[7] = '{8'h4B, 8'h25, 8'h4A, 8'h25, 8'hDA, 8'h00, 8'h00};
    logic [W-1:0] e;
    en = 1'b1; mode = 3'b001; d = 8'hA5;
    exp_q.push_back(8'hA5);
    tick();
    for (int i = -1; i < 8; i++) begin
      if (i >= 0 && i < 7) begin
        mode = m_tab[i]; sin = s_tab[i]; d = 8'h3C;
        exp_q.push_back(e_tab[i]);
        tick();
      end else if (i == 7) begin
        // disabled clock: invert must not apply
        en = 1'b0; mode = 3'b111;
        exp_q.push_back(8'h00);
        tick();
        en = 1'b1;
      end
      e = exp_q.pop_front();
      tests_run++;
      if (q_m !== e || qn_m !== ~e || q_l !== e || qn_l !== ~e) begin
        failures++;
        $display("FAIL mode_step%0d mode=%b: q=%h/%h qn=%h/%h, expected q=%h qn=%h",
                 i, mode, q_m, q_l, qn_m, qn_l, e, ~e);
      end
    end
    mode = 3'b000; sin = 1'b0; d = '0;
  endtask

  // Runs one frame of data; stall/inject/abort are bit indices (-1 = unused).
  task automatic run_frame(input logic [W-1:0] data, input int stall_at, input int stall_len,
                           input int inject_at, input int abort_at);
    int           cycles;
    bit           em, el;
    logic [W-1:0] hold_m, hold_l;
    en = 1'b1; start = 1'b1; d = data; mode = 3'b111; sin = 1'b0;
    for (int i = 0; i < W; i++) begin
      exp_m.push_back(data[W-1-i]);
      exp_l.push_back(data[i]);
    end
    tick();
    start = 1'b0; mode = 3'b000; d = '0;
    cycles = 0;
    for (int i = 0; i < W; i++) begin
      em = exp_m.pop_front();
      el = exp_l.pop_front();
      tests_run++;
      if (sout_m !== em || sout_l !== el || busy_m !== 1'b1 || busy_l !== 1'b1 ||
          done_m !== 1'b0 || done_l !== 1'b0) begin
        failures++;
        $display("FAIL frame_%h_bit%0d: sout=%b/%b busy=%b/%b done=%b/%b, expected sout=%b/%b busy=1 done=0",
                 data, i, sout_m, sout_l, busy_m, busy_l, done_m, done_l, em, el);
      end
      if (i == abort_at) begin
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tests_run++;
        if (busy_m !== 1'b0 || busy_l !== 1'b0 || q_m !== 8'h00 || q_l !== 8'h00 ||
            done_m !== 1'b0 || done_l !== 1'b0) begin
          failures++;
          $display("FAIL abort_reset: busy=%b/%b q=%h/%h done=%b/%b, expected busy=0 q=00 done=0",
                   busy_m, busy_l, q_m, q_l, done_m, done_l);
        end
        tick();
        tests_run++;
        if (done_m !== 1'b0 || done_l !== 1'b0 || busy_m !== 1'b0 || busy_l !== 1'b0) begin
          failures++;
          $display("FAIL abort_no_done: done=%b/%b busy=%b/%b, expected done=0 busy=0",
                   done_m, done_l, busy_m, busy_l);
        end
        exp_m.delete();
        exp_l.delete();
        return;
      end
      if (i == stall_at) begin
        hold_m = q_m; hold_l = q_l;
        en = 1'b0;
        for (int s = 0; s < stall_len; s++) begin
          tick();
          cycles++;
          tests_run++;
          if (q_m !== hold_m || q_l !== hold_l || sout_m !== em || sout_l !== el ||
              busy_m !== 1'b1 || busy_l !== 1'b1 || done_m !== 1'b0) begin
            failures++;
            $display("FAIL stall_cycle%0d: q=%h/%h sout=%b/%b busy=%b/%b done=%b, expected q=%h/%h sout=%b/%b busy=1 done=0",
                     s, q_m, q_l, sout_m, sout_l, busy_m, busy_l, done_m, hold_m, hold_l, em, el);
          end
        end
        en = 1'b1;
      end
      if (i == inject_at) begin
        start = 1'b1; d = '1; mode = 3'b001;
      end
      tick();
      cycles++;
      start = 1'b0; mode = 3'b000; d = '0;
    end
    tests_run++;
    if (done_m !== 1'b1 || done_l !== 1'b1 || busy_m !== 1'b0 || busy_l !== 1'b0 ||
        q_m !== 8'h00 || q_l !== 8'h00 || cycles !== W + stall_len) begin
      failures++;
      $display("FAIL frame_%h_end: done=%b/%b busy=%b/%b q=%h/%h cycles=%0d, expected done=1 busy=0 q=00 cycles=%0d",
               data, done_m, done_l, busy_m, busy_l, q_m, q_l, cycles, W + stall_len);
    end
  endtask

  task automatic check_idle_after(input string name);
    tick();
    tests_run++;
    if (done_m !== 1'b0 || done_l !== 1'b0 || busy_m !== 1'b0 || busy_l !== 1'b0) begin
      failures++;
      $display("FAIL %s_post: done=%b/%b busy=%b/%b, expected done=0 busy=0",
               name, done_m, done_l, busy_m, busy_l);
    end
  endtask

  task automatic test_serialize();
    run_frame(8'hC3, -1, 0, -1, -1);
    check_idle_after("serialize");
  endtask

  task automatic test_stall();
    run_frame(8'hC3, 2, 3, -1, -1);
    check_idle_after("stall");
  endtask

  task automatic test_reset_mid_frame();
    run_frame(8'hC3, -1, 0, -1, 3);
    run_frame(8'h96, -1, 0, -1, -1);
    check_idle_after("after_abort");
  endtask

  task automatic test_start_qual();
    run_frame(8'hB1, -1, 0, 4, -1);
    check_idle_after("inject");
    en = 1'b0; start = 1'b1; d = 8'hFF; mode = 3'b001;
    tick();
    tick();
    tests_run++;
    if (busy_m !== 1'b0 || busy_l !== 1'b0 || q_m !== 8'h00 || q_l !== 8'h00 || done_m !== 1'b0) begin
      failures++;
      $display("FAIL start_en0: busy=%b/%b q=%h/%h done=%b, expected busy=0 q=00 done=0",
               busy_m, busy_l, q_m, q_l, done_m);
    end
    start = 1'b0; mode = 3'b000; d = '0; en = 1'b1;
    check_idle_after("start_en0");
  endtask

  task automatic test_back_to_back();
    run_frame(8'hC3, -1, 0, -1, -1);
    run_frame(8'h5A, -1, 0, -1, -1);
    check_idle_after("back_to_back");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_modes();
    test_serialize();
    test_stall();
    test_reset_mid_frame();
    test_start_qual();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests_run, failures);
    $finish;
  end

endmodule
